// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 7-segment scan bus. Each digit must be stable before it is decoded back to BCD.
// Once all four positions have been seen, the digits are committed together as one mm:ss frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT        = 65535,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] shape,
    input  logic [3:0] choose_light_sig,
    output logic [3:0] mX,
    output logic [3:0] mU,
    output logic [3:0] sX,
    output logic [3:0] sU,
    output logic [3:0] dp,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       sel_err,
    output logic       stale
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [11:0]   POL_MASK = {{4{SEL_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};

    typedef enum logic [1:0] {ST_SETTLE, ST_CAPTURE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [11:0]     sync1_q, sync2_q, prev_q;
    logic [11:0]     sample_n;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic [15:0]     shadow_val_q, shadow_val_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic [3:0]      mask_q, mask_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      dp_q, dp_d;
    logic            frame_valid_q, frame_valid_d;
    logic            seg_err_q, seg_err_d;
    logic            sel_err_q, sel_err_d;
    logic            stale_q, stale_d;
    logic            changed, commit, sel_onehot;
    logic [3:0]      cap_sel;
    logic [7:0]      cap_seg;
    logic [4:0]      dec;

    // Returns {error, value}; a blank digit decodes to F without error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h00:   decode = 5'h0F;
            default: decode = 5'h1E;
        endcase
    endfunction

    assign sample_n   = sync2_q ^ POL_MASK;
    assign changed    = (sample_n != prev_q);
    // The capture cycle uses the previous sample, which still holds the stable value even if the pins have just moved.
    assign cap_sel    = prev_q[11:8];
    assign cap_seg    = prev_q[7:0];
    assign sel_onehot = (cap_sel != 4'd0) && ((cap_sel & (cap_sel - 4'd1)) == 4'd0);
    assign dec        = decode(cap_seg[6:0]);

    always_comb begin
        cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
        state_d = state_q;
        case (state_q)
            ST_SETTLE:  if (!changed && cnt_d == CNT_MAX) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = changed ? ST_SETTLE : ST_HOLD;
            ST_HOLD:    if (changed) state_d = ST_SETTLE;
            default:    state_d = ST_SETTLE;
        endcase
    end

    always_comb begin
        mask_d        = mask_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        frame_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        sel_err_d     = 1'b0;
        commit        = 1'b0;
        if (state_q == ST_CAPTURE && cap_sel != 4'd0) begin
            if (!sel_onehot) begin
                sel_err_d = 1'b1;
            end else begin
                seg_err_d = dec[4];
                for (int i = 0; i < 4; i++) begin
                    if (cap_sel[i]) begin
                        shadow_val_d[i*4 +: 4] = dec[3:0];
                        shadow_dp_d[i]         = cap_seg[7];
                    end
                end
                mask_d = mask_q | cap_sel;
                if (mask_d == 4'hF) begin
                    commit        = 1'b1;
                    digits_d      = shadow_val_d;
                    dp_d          = shadow_dp_d;
                    mask_d        = 4'd0;
                    frame_valid_d = 1'b1;
                end
            end
        end
        timeout_d = commit ? '0 : ((timeout_q == TO_MAX) ? timeout_q : timeout_q + TW'(1));
        stale_d   = commit ? 1'b0 : (stale_q || (timeout_d == TO_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= POL_MASK;
            sync2_q       <= POL_MASK;
            prev_q        <= '0;
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            timeout_q     <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            mask_q        <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            sel_err_q     <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            sync1_q       <= {choose_light_sig, shape};
            sync2_q       <= sync1_q;
            prev_q        <= sample_n;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            sel_err_q     <= sel_err_d;
            stale_q       <= stale_d;
        end
    end

    assign mX          = digits_q[15:12];
    assign mU          = digits_q[11:8];
    assign sX          = digits_q[7:4];
    assign sU          = digits_q[3:0];
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign sel_err     = sel_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Drives the active-low scan bus with held digit values.
// Checks the decoder against a frame-level reference model of captures, decodes and commits.
module tb_seg_scan_decoder;
    localparam int SC = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] shape = 8'hFF;
    logic [3:0] choose_light_sig = 4'hF;
    logic [3:0] mX, mU, sX, sU, dp;
    logic       frame_valid, seg_err, sel_err, stale;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(SC), .TIMEOUT(TO), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .shape(shape), .choose_light_sig(choose_light_sig),
        .mX(mX), .mU(mU), .sX(sX), .sU(sU), .dp(dp),
        .frame_valid(frame_valid), .seg_err(seg_err), .sel_err(sel_err), .stale(stale)
    );

    int compared = 0, mismatched = 0;
    int mon_fv = 0, mon_seg = 0, mon_sel = 0;
    int exp_fv = 0, exp_seg = 0, exp_sel = 0;
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_sdp, m_mask, m_dp;
    logic [15:0] m_digits, prev_digits;
    logic [3:0]  last_sel;
    logic [7:0]  last_seg;
    int          run_len;
    bit          run_cap;
    logic [6:0]  lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference: one capture per stable run, assembled into frames by position.
    task automatic model_capture(input logic [3:0] sel, input logic [7:0] seg);
        logic [3:0] val;
        int idx;
        if (sel == 4'd0) return;
        if ($countones(sel) != 1) begin exp_sel++; return; end
        val = 4'hE;
        if (seg[6:0] == 7'd0) val = 4'hF;
        for (int k = 0; k < 10; k++) if (seg[6:0] == lut[k]) val = 4'(k);
        if (val == 4'hE) exp_seg++;
        idx = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        m_shadow[idx] = val;
        m_sdp[idx] = seg[7];
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            m_dp = m_sdp;
            m_mask = 4'd0;
            exp_fv++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
        m_sdp = 0; m_mask = 0; m_dp = 0; m_digits = 0;
        last_sel = 0; last_seg = 0; run_len = 0; run_cap = 0;
    endtask

    // Drive an active-high (sel, seg) onto the active-low bus for n cycles, tallying output pulses.
    task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
        shape = ~seg;
        choose_light_sig = ~sel;
        if (sel !== last_sel || seg !== last_seg) begin
            last_sel = sel; last_seg = seg; run_len = 0; run_cap = 0;
        end
        run_len += n;
        if (!run_cap && run_len >= SC) begin run_cap = 1; model_capture(sel, seg); end
        repeat (n) begin
            @(negedge clk);
            if (frame_valid === 1'b1) mon_fv++;
            if (seg_err === 1'b1) mon_seg++;
            if (sel_err === 1'b1) mon_sel++;
            if ({mX, mU, sX, sU} !== prev_digits) begin
                compared++;
                if (frame_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL digits_between_commits: got %h (was %h) with frame_valid=%b, required change only with frame_valid=1",
                             {mX, mU, sX, sU}, prev_digits, frame_valid);
                end
                prev_digits = {mX, mU, sX, sU};
            end
        end
    endtask

    task automatic do_reset();
        shape = 8'hFF;
        choose_light_sig = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev_digits = 16'h0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({mX, mU, sX, sU, dp} !== 20'h0) begin
            mismatched++; $display("FAIL reset_digits: got %h required 0", {mX, mU, sX, sU, dp});
        end
        compared++;
        if ({frame_valid, seg_err, sel_err} !== 3'b000) begin
            mismatched++; $display("FAIL reset_pulses: got %b required 000", {frame_valid, seg_err, sel_err});
        end
        compared++;
        if (stale !== 1'b1) begin mismatched++; $display("FAIL reset_stale: got %b required 1", stale); end
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        int fv0 = mon_fv;
        hold(4'b1000, 8'h06, 10);
        compared++;
        if (stale !== 1'b1) begin mismatched++; $display("FAIL basic_stale_before: got %b required 1", stale); end
        hold(4'b0100, 8'h5B, 10);
        hold(4'b0010, 8'h4F, 10);
        hold(4'b0001, 8'h66, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if ({mX, mU, sX, sU} !== 16'h1234) begin
            mismatched++; $display("FAIL basic_digits: got %h required 1234", {mX, mU, sX, sU});
        end
        compared++;
        if (mon_fv - fv0 !== 1) begin mismatched++; $display("FAIL basic_fv_count: got %0d required 1", mon_fv - fv0); end
        compared++;
        if (stale !== 1'b0) begin mismatched++; $display("FAIL basic_stale_after: got %b required 0", stale); end
        $display("test_basic_frame digits=%h fv=%0d", {mX, mU, sX, sU}, mon_fv - fv0);
    endtask

    task automatic test_stability();
        int fv0 = mon_fv;
        int se0 = mon_seg;
        hold(4'b1000, {1'b0, lut[7]}, 3);
        hold(4'b0100, {1'b0, lut[5]}, 10);
        hold(4'b0010, {1'b0, lut[0]}, 10);
        hold(4'b0001, {1'b1, lut[9]}, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if (mon_fv - fv0 !== 0) begin mismatched++; $display("FAIL short_hold_no_frame: got %0d frames required 0", mon_fv - fv0); end
        hold(4'b1000, {1'b1, lut[8]}, 4);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if (mon_fv - fv0 !== 1 || {mX, mU, sX, sU} !== 16'h8509 || dp !== 4'b1001) begin
            mismatched++;
            $display("FAIL four_cycle_capture: got frames=%0d digits=%h dp=%b required 1/8509/1001", mon_fv - fv0, {mX, mU, sX, sU}, dp);
        end
        hold(4'b0010, 8'h49, 20);
        hold(4'b1000, {1'b0, lut[2]}, 10);
        hold(4'b0100, {1'b0, lut[3]}, 10);
        hold(4'b0001, 8'h00, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if (mon_seg - se0 !== 1) begin mismatched++; $display("FAIL long_hold_one_seg_err: got %0d required 1", mon_seg - se0); end
        compared++;
        if ({mX, mU, sX, sU} !== 16'h23EF || mon_fv - fv0 !== 2) begin
            mismatched++; $display("FAIL seg_err_frame: got digits=%h frames=%0d required 23EF/2", {mX, mU, sX, sU}, mon_fv - fv0);
        end
        $display("test_stability digits=%h seg_err=%0d", {mX, mU, sX, sU}, mon_seg - se0);
    endtask

    task automatic test_select();
        int sl0 = mon_sel;
        int se0 = mon_seg;
        hold(4'b1000, {1'b0, lut[5]}, 10);
        hold(4'b0100, {1'b0, lut[6]}, 10);
        hold(4'b0001, {1'b0, lut[7]}, 10);
        hold(4'b1100, {1'b0, lut[8]}, 20);
        hold(4'b0000, {1'b0, lut[9]}, 20);
        compared++;
        if (mon_sel - sl0 !== 1 || mon_seg - se0 !== 0) begin
            mismatched++; $display("FAIL sel_err_once: got sel=%0d seg=%0d required 1/0", mon_sel - sl0, mon_seg - se0);
        end
        hold(4'b0010, {1'b0, lut[0]}, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if ({mX, mU, sX, sU} !== 16'h5607) begin
            mismatched++; $display("FAIL sel_err_mask_kept: got %h required 5607", {mX, mU, sX, sU});
        end
        $display("test_select digits=%h sel_err=%0d", {mX, mU, sX, sU}, mon_sel - sl0);
    endtask

    task automatic test_mid_reset();
        int fv0;
        hold(4'b1000, {1'b0, lut[1]}, 10);
        hold(4'b0100, {1'b0, lut[1]}, 10);
        hold(4'b0010, {1'b0, lut[1]}, 10);
        do_reset();
        fv0 = mon_fv;
        hold(4'b0001, {1'b0, lut[1]}, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if ({mX, mU, sX, sU} !== 16'h0 || mon_fv - fv0 !== 0) begin
            mismatched++; $display("FAIL mid_reset_discard: got digits=%h frames=%0d required 0000/0", {mX, mU, sX, sU}, mon_fv - fv0);
        end
        hold(4'b1000, {1'b0, lut[4]}, 10);
        hold(4'b0100, {1'b0, lut[2]}, 10);
        hold(4'b0010, {1'b0, lut[4]}, 10);
        hold(4'b0000, 8'h00, 10);
        compared++;
        if (mon_fv - fv0 !== 1 || {mX, mU, sX, sU} !== 16'h4241) begin
            mismatched++; $display("FAIL mid_reset_fresh: got digits=%h frames=%0d required 4241/1", {mX, mU, sX, sU}, mon_fv - fv0);
        end
        $display("test_mid_reset digits=%h", {mX, mU, sX, sU});
    endtask

    task automatic test_stale();
        bit found = 0;
        hold(4'b1000, {1'b0, lut[3]}, 10);
        hold(4'b0100, {1'b0, lut[1]}, 10);
        hold(4'b0010, {1'b0, lut[4]}, 10);
        for (int k = 0; k < 40 && !found; k++) begin
            hold(4'b0001, {1'b0, lut[1]}, 1);
            if (frame_valid === 1'b1) found = 1;
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL stale_commit_seen: got no frame_valid within 40 cycles required 1"); end
        compared++;
        if (stale !== 1'b0) begin mismatched++; $display("FAIL stale_clear_on_commit: got %b required 0", stale); end
        for (int k = 0; k < TO - 1; k++) hold(4'b0001, {1'b0, lut[1]}, 1);
        compared++;
        if (stale !== 1'b0) begin mismatched++; $display("FAIL stale_early: got %b at %0d cycles required 0", stale, TO - 1); end
        hold(4'b0001, {1'b0, lut[1]}, 1);
        compared++;
        if (stale !== 1'b1) begin mismatched++; $display("FAIL stale_rise: got %b at %0d cycles required 1", stale, TO); end
        hold(4'b1000, {1'b0, lut[0]}, 10);
        hold(4'b0100, {1'b0, lut[9]}, 10);
        hold(4'b0010, {1'b0, lut[5]}, 10);
        hold(4'b0001, {1'b0, lut[9]}, 10);
        hold(4'b0000, 8'h00, 5);
        compared++;
        if (stale !== 1'b0 || {mX, mU, sX, sU} !== 16'h0959) begin
            mismatched++; $display("FAIL stale_recover: got stale=%b digits=%h required 0/0959", stale, {mX, mU, sX, sU});
        end
        $display("test_stale stale=%b digits=%h", stale, {mX, mU, sX, sU});
    endtask

    task automatic test_random();
        logic [3:0] sel;
        logic [6:0] seg7;
        int r;
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) sel = 4'd0;
            else if (r == 1) sel = 4'($urandom);
            else sel = 4'b0001 << $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 7) seg7 = lut[$urandom_range(0, 9)];
            else if (r == 7) seg7 = 7'd0;
            else seg7 = 7'($urandom);
            hold(sel, {1'($urandom), seg7}, $urandom_range(2, 12));
        end
        hold(4'b0000, 8'h00, 20);
        $display("test_random frames=%0d seg_err=%0d sel_err=%0d", mon_fv, mon_seg, mon_sel);
    endtask

    task automatic test_model_agree(input string tag);
        compared++;
        if ({mX, mU, sX, sU} !== m_digits || dp !== m_dp) begin
            mismatched++;
            $display("FAIL %s_digits: got %h dp=%b required %h dp=%b", tag, {mX, mU, sX, sU}, dp, m_digits, m_dp);
        end
        compared++;
        if (mon_fv != exp_fv || mon_seg != exp_seg || mon_sel != exp_sel) begin
            mismatched++;
            $display("FAIL %s_pulses: got fv/seg/sel=%0d/%0d/%0d required %0d/%0d/%0d", tag, mon_fv, mon_seg, mon_sel, exp_fv, exp_seg, exp_sel);
        end
    endtask

    initial begin
        model_reset();
        prev_digits = 16'h0;
        test_reset();
        test_basic_frame();
        test_model_agree("basic");
        test_stability();
        test_model_agree("stability");
        test_select();
        test_model_agree("select");
        test_mid_reset();
        test_model_agree("mid_reset");
        test_stale();
        test_model_agree("stale");
        test_random();
        test_model_agree("random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reader for the multiplexed 7-segment bus driven by the clock's display block (shape, choose_light_sig).
- Filters the scanned segment/select lines, decodes each stable digit back to BCD and reassembles full mm:ss frames.
- Used as a loopback monitor in the clock top and as a self-checking probe in benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (≥2).
- TIMEOUT, 65535: cycles without a committed frame before stale asserts.
- SEG_ACTIVE_LOW, 1: 1 = shape bits are active-low.
- SEL_ACTIVE_LOW, 1: 1 = choose_light_sig bits are active-low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- shape  in  8  segments: [0]=a … [6]=g, [7]=dp
- choose_light_sig  in  4  digit select: [3]=mX, [2]=mU, [1]=sX, [0]=sU
- mX, mU, sX, sU  out  4 each  committed digit values
- dp  out  4  committed decimal points, same bit order as select
- frame_valid  out  1  one-cycle pulse when a new frame is committed
- seg_err  out  1  one-cycle pulse: undecodable pattern captured
- sel_err  out  1  one-cycle pulse: stable select not one-hot and not all-off
- stale  out  1  no frame committed within TIMEOUT cycles

Behaviour:
- Reset (async, rst_n=0): digits 0, dp 0, frame_valid/seg_err/sel_err 0, stale 1, seen mask 0, shadow regs 0, FSM SETTLE, stability counter 0, timeout counter 0.
- Input path: 2-flop synchroniser on all 12 bits, then polarity normalisation per parameters (internal: 1 = lit/selected).
- Stability: compare normalised sample to previous sample. Differ → counter 0, FSM SETTLE. Equal → counter increments, saturating at STABLE_CYCLES-1.
- FSM SETTLE → CAPTURE when counter reaches STABLE_CYCLES-1. CAPTURE lasts one cycle, then HOLD. HOLD → SETTLE on any sample change. Exactly one capture per stable interval.
- Capture with sel all-off: ignored, no flags.
- Capture with sel not one-hot: sel_err pulse; shadow and mask unchanged.
- Capture with sel one-hot: decode seg[6:0] into shadow[sel], store dp into shadow dp, set mask bit.
- Decode table (gfedcba, active-high):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 00 = blank, value F, no error.
  - Any other pattern: value E, seg_err pulse. The mask bit is still set.
- Repeat capture of an already-seen position overwrites its shadow; mask unchanged.
- Commit: on the capture that makes mask=1111, on the same clock edge:
  - outputs load from shadow (the just-captured digit included);
  - mask clears, timeout counter clears, stale clears.
  - frame_valid is high for the following cycle only.
- Latency: pin change → 2 sync cycles + STABLE_CYCLES samples → capture edge. Digit outputs are otherwise constant between commits.
- Timeout: counter increments each cycle without a commit and saturates at TIMEOUT. Reaching TIMEOUT sets stale; stale stays set until the next commit.
- Error pulses and frame_valid may coincide.
- Reset mid-frame discards the partial mask and shadow.

Test Plan:
- Active-low bus scans 1,2,3,4 (shape=~8'h06, choose=4'b0111; then ~5B/1011, ~4F/1101, ~66/1110), each held 10 cycles → after the 4th capture: mX=1, mU=2, sX=3, sU=4; one frame_valid pulse; stale 1→0.
- Select held 3 cycles with STABLE_CYCLES=4 → no capture, mask unchanged. Held 4 cycles → capture exactly once; 20-cycle hold → still one capture.
- Pattern 8'h49 on sX in an otherwise valid frame → seg_err pulse, sX=E after commit, frame_valid still pulses.
- choose_light_sig=4'b0011 stable → sel_err pulse once, no mask change. 4'b1111 (all off) → no flags.
- Three digits captured, then rst_n low mid-frame, then one digit → outputs remain 0, no frame_valid until four fresh captures.
- TIMEOUT=100, scan stopped after one commit → stale rises at 100 cycles after the commit and clears on the next commit.
